// File: rtl/clk_div_monitor.sv
// ---------------------------------------------------------------------------
// clk_div_monitor
//
// Watches the output of the programmable clock divider from the source clock
// domain. The divided clock is synchronised and turned into one-cycle rise
// and fall strobes. Rise-to-rise and rise-to-fall times are measured in
// source cycles. Lock is declared once LOCK_CNT consecutive periods equal DIV.
// A sticky error flags a ratio change after lock, or a lost divided clock.
//
// Ports
//   clk         in   source clock (also feeds the divider)
//   rst         in   asynchronous active-high reset
//   div_clk_in  in   divided clock under observation (asynchronous)
//   en          in   monitor enable, level
//   err_clr     in   one-cycle pulse, clears err
//   rise_pulse  out  one-cycle strobe per synchronised rising edge
//   fall_pulse  out  one-cycle strobe per synchronised falling edge
//   period      out  last rise-to-rise time in clk cycles
//   high_time   out  last rise-to-fall time in clk cycles
//   locked      out  ratio confirmed
//   err         out  sticky: mismatch after lock, or timeout
// ---------------------------------------------------------------------------
module clk_div_monitor #(
    parameter int DIV         = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CNT    = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_clk_in,
    input  logic             en,
    input  logic             err_clr,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             locked,
    output logic             err
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_EDGE = 2'd1;
    localparam logic [1:0] MEASURE   = 2'd2;
    localparam logic [1:0] LOCKED    = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] DIV_C   = CNT_W'(DIV);
    localparam logic [3:0]       LOCK_C  = 4'(LOCK_CNT);
    localparam bit               DIV_OK  = (DIV >= 2);

    // Saturating increment: the counter sticks at all-ones, which is what
    // the timeout detector looks for.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_d;

    logic [1:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [3:0]       match, match_nx;
    logic             lock_nx;
    logic             set_err;
    logic             upd_per;
    logic             upd_high;
    logic             measuring;

    // Synchroniser stage plus one delay flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= '0;
            sync_d <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], div_clk_in};
            sync_d <= sync[SYNC_STAGES-1];
        end
    end

    // Strobes come straight from flops and ignore en
    assign rise_pulse = sync[SYNC_STAGES-1] & ~sync_d;
    assign fall_pulse = ~sync[SYNC_STAGES-1] & sync_d;

    assign measuring = (state == MEASURE) || (state == LOCKED);

    always_comb begin
        state_nx = state;
        match_nx = match;
        lock_nx  = locked;
        set_err  = 1'b0;
        upd_per  = 1'b0;
        upd_high = 1'b0;

        if (state == IDLE)
            cnt_nx = '0;
        else if (rise_pulse)
            cnt_nx = CNT_W'(1);
        else
            cnt_nx = sat_inc(cnt);

        if (!en) begin
            state_nx = IDLE;
            match_nx = '0;
            lock_nx  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    match_nx = '0;
                    lock_nx  = 1'b0;
                    if (DIV_OK)
                        state_nx = WAIT_EDGE;
                end
                WAIT_EDGE: begin
                    // First edge only starts the measurement window
                    if (rise_pulse) begin
                        state_nx = MEASURE;
                        match_nx = '0;
                    end
                end
                MEASURE: begin
                    if (rise_pulse) begin
                        upd_per = 1'b1;
                        if (cnt == DIV_C) begin
                            match_nx = 4'(match + 4'd1);
                            if (4'(match + 4'd1) == LOCK_C) begin
                                state_nx = LOCKED;
                                lock_nx  = 1'b1;
                            end
                        end else begin
                            match_nx = '0;
                        end
                    end
                end
                default: begin // LOCKED
                    if (rise_pulse) begin
                        upd_per = 1'b1;
                        if (cnt != DIV_C) begin
                            set_err  = 1'b1;
                            lock_nx  = 1'b0;
                            match_nx = '0;
                            state_nx = MEASURE;
                        end
                    end
                end
            endcase

            if (measuring && fall_pulse)
                upd_high = 1'b1;

            // Lost clock: counter pinned at its ceiling overrides edge handling
            if (measuring && cnt == CNT_MAX) begin
                set_err  = 1'b1;
                lock_nx  = 1'b0;
                match_nx = '0;
                state_nx = WAIT_EDGE;
            end
        end
    end

    // Measurement / control register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            match     <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            period    <= '0;
            high_time <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            match  <= match_nx;
            locked <= lock_nx;
            // A new error wins over a simultaneous clear
            err    <= set_err | (err & ~err_clr);
            if (upd_per)
                period <= cnt;
            if (upd_high)
                high_time <= cnt;
        end
    end

endmodule
